// File: rtl/nibble_add_seq.sv
// Nibble-serial adder: operands are captured on accept, then summed one 4-bit
// slice per cycle, LSB first, with the slice carry registered between nibbles.
module nibble_add_seq #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4*NIB-1:0] in_a,
    input  logic [4*NIB-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4*NIB-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf,
    output logic             busy
);

    localparam int W     = 4 * NIB;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, b_q;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last;
    logic [IDX_W+1:0] shamt;
    logic [3:0]       nib_a, nib_b, nib_s;
    logic             nib_c;

    // Single 4-bit ripple slice: per-bit xor sum and majority carry.
    function automatic logic [4:0] ripple4(input logic [3:0] a, input logic [3:0] b,
                                           input logic ci);
        logic       c;
        logic [3:0] s;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        return {c, s};
    endfunction

    assign accept = in_valid & in_ready & ~rst;
    assign last   = (idx_q == IDX_W'(NIB - 1));
    assign shamt  = {idx_q, 2'b00};
    assign nib_a  = 4'(a_q >> shamt);
    assign nib_b  = 4'(b_q >> shamt);
    assign {nib_c, nib_s} = ripple4(nib_a, nib_b, carry_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ADD;
            ADD:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == ADD);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        if (accept) begin
            sum_d   = '0;
            idx_d   = '0;
            carry_d = in_cin;
            co_d    = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == ADD) begin
            sum_d   = (sum_q & ~(W'(4'hF) << shamt)) | (W'(nib_s) << shamt);
            carry_d = nib_c;
            // Index holds on the last nibble; it is only cleared by the next accept.
            if (last) begin
                co_d  = nib_c;
                ovf_d = (a_q[W-1] == b_q[W-1]) & (nib_s[3] != a_q[W-1]);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand holding registers carry no reset; they are only read after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    assign out_sum = sum_q;
    assign out_co  = co_q;
    assign out_ovf = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: vector table plus scoreboard queue,
// with hand sequences for back-pressure, mid-operation reset and NIB=1.
module tb_nibble_add_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_co, out_ovf, busy;

    logic         n1_in_valid, n1_in_ready, n1_in_cin;
    logic [3:0]   n1_in_a, n1_in_b, n1_out_sum;
    logic         n1_out_valid, n1_out_ready, n1_out_co, n1_out_ovf, n1_busy;

    nibble_add_seq #(.NIB(NIB)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co),
        .out_ovf(out_ovf), .busy(busy)
    );

    nibble_add_seq #(.NIB(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
        .in_a(n1_in_a), .in_b(n1_in_b), .in_cin(n1_in_cin), .out_valid(n1_out_valid),
        .out_ready(n1_out_ready), .out_sum(n1_out_sum), .out_co(n1_out_co),
        .out_ovf(n1_out_ovf), .busy(n1_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        int           hold;
    } vec_t;

    exp_t   sbq[$];
    int     checks = 0;
    int     errors = 0;
    time    t_acc, t_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t         e;
        logic [W:0]   t;
        t     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum = t[W-1:0];
        e.co  = t[W];
        e.ovf = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        return e;
    endfunction

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input exp_t e_in, input int hold);
        exp_t e;
        int   cyc;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        sbq.push_back(e_in);
        t_prev   = t_acc;
        t_acc    = $time;
        @(negedge clk);
        in_valid = 1'b0;
        cyc      = 1;
        while (!out_valid && cyc < 20) begin
            if (cyc == 1) chk("busy_add", 32'(busy), 32'd1);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_cin    = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", 32'(cyc), 32'(NIB + 1));
        e = sbq.pop_front();
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_sum", 32'(out_sum), 32'(e.sum));
            chk("hold_co", 32'(out_co), 32'(e.co));
        end
        in_valid = 1'b0;
        chk("sum", 32'(out_sum), 32'(e.sum));
        chk("co", 32'(out_co), 32'(e.co));
        chk("ovf", 32'(out_ovf), 32'(e.ovf));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sum: 16'h5555, co: 1'b0, ovf: 1'b0, hold: 0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sum: 16'h0000, co: 1'b1, ovf: 1'b0, hold: 0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sum: 16'h8000, co: 1'b0, ovf: 1'b1, hold: 0};
        vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sum: 16'h0000, co: 1'b1, ovf: 1'b1, hold: 0};
        vecs[4] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sum: 16'h5556, co: 1'b0, ovf: 1'b0, hold: 10};
        vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sum: 16'hFFFF, co: 1'b1, ovf: 1'b0, hold: 3};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        n1_in_valid = 1'b0; n1_in_a = '0; n1_in_b = '0; n1_in_cin = 1'b0; n1_out_ready = 1'b0;
        t_acc = 0; t_prev = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_co", 32'(out_co), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.sum = vecs[i].sum; e.co = vecs[i].co; e.ovf = vecs[i].ovf;
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, e, vecs[i].hold);
        end

        // Reset in the second ADD cycle aborts the operation.
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(out_sum), 32'd0);
        chk("abort_co", 32'(out_co), 32'd0);
        chk("abort_ovf", 32'(out_ovf), 32'd0);

        // Reset wins over a simultaneous offer.
        in_valid = 1'b1; in_a = 16'hABCD;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 32'd0);
        chk("rst_prio_ready", 32'(in_ready), 32'd1);
        run_op(16'h0F0F, 16'h00F1, 1'b0, model(16'h0F0F, 16'h00F1, 1'b0), 0);

        // Back-to-back random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            logic         c;
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            run_op(a, b, c, model(a, b, c), (i % 5 == 4) ? 2 : 0);
            if (i > 0 && (i % 5) != 0) chk("throughput", 32'((t_acc - t_prev) / 10), 32'(NIB + 2));
        end

        // NIB=1 instance: exactly one ADD cycle.
        n1_in_valid = 1'b1; n1_in_a = 4'h7; n1_in_b = 4'h1; n1_in_cin = 1'b0;
        @(negedge clk);
        n1_in_valid = 1'b0;
        chk("n1_busy", 32'(n1_busy), 32'd1);
        @(negedge clk);
        chk("n1_out_valid", 32'(n1_out_valid), 32'd1);
        chk("n1_busy_off", 32'(n1_busy), 32'd0);
        chk("n1_sum", 32'(n1_out_sum), 32'h8);
        chk("n1_co", 32'(n1_out_co), 32'd0);
        chk("n1_ovf", 32'(n1_out_ovf), 32'd1);
        n1_out_ready = 1'b1;
        @(negedge clk);
        n1_out_ready = 1'b0;
        chk("n1_in_ready", 32'(n1_in_ready), 32'd1);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
